aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Control FSM for the byte-serial AES-128 encryption datapath (key expansion + MixColumns/AddRoundKey path).
//  Sequences load, 10 rounds of key expansion and data processing, and serial output.
//  Generates round number, Rcon and per-stage enables; the byte datapath itself is external.
//  Handshakes with the byte source (in_valid) and the byte sink (out_ready).
// PARAMETERS
//  NR     10  number of rounds (AES-128)
//  NBYTES 16  bytes per state/key block; byte_idx wraps at NBYTES-1
// PORTS
//  clk       in   1  clock, all state changes on rising edge
//  rst       in   1  asynchronous, active-high reset
//  start     in   1  begin an encryption; sampled only in IDLE
//  in_valid  in   1  source presents key byte + plaintext byte this cycle
//  out_ready in   1  sink accepts the ciphertext byte this cycle
//  busy      out  1  high in every state except IDLE
//  load_en   out  1  datapath captures input bytes (= in_valid in LOAD)
//  ke_en     out  1  key-expansion step enable
//  sb_en     out  1  SubBytes/ShiftRows enable
//  mc_en     out  1  MixColumns enable (low in final round)
//  ark_en    out  1  AddRoundKey enable
//  out_valid out  1  ciphertext byte valid
//  byte_idx  out  4  byte position within block, 0..15
//  round     out  4  current round, 0 during LOAD, 1..NR thereafter
//  rcon      out  8  round constant for current round
//  done      out  1  single-cycle pulse: block finished
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, byte_idx=0, round=0, rcon=8'h01; all 1-bit outputs 0.
//  Reset mid-operation: abandons the block immediately, no done pulse; outputs per reset values.
//  States: IDLE, LOAD, KEYEXP, DATA, OUTPUT. Outputs are Moore decodes of registers, except load_en/ark_en in LOAD.
//  IDLE: start=1 -> LOAD, byte_idx=0, round=0. start while busy is ignored (no queueing).
//  LOAD: load_en=ark_en=in_valid (round-0 whitening). byte_idx++ only when in_valid.
//    in_valid & byte_idx==15 -> KEYEXP, byte_idx=0, round=1, rcon=8'h01.
//  KEYEXP: ke_en=1 every cycle, byte_idx++ unconditionally; at 15 -> DATA, byte_idx=0.
//  DATA: sb_en=1, ark_en=1, mc_en=(round!=NR); byte_idx++ unconditionally; at byte_idx==15:
//    round<NR -> KEYEXP, round++, rcon=xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7]?8'h1b:8'h00).
//    round==NR -> OUTPUT, byte_idx=0 (round, rcon hold).
//  Rcon sequence rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
//  OUTPUT: out_valid=1; byte_idx++ only when out_ready. out_ready & byte_idx==15 -> IDLE, done=1 for exactly
//    the first IDLE cycle; round->0, rcon->01, byte_idx->0.
//  Stalls: in_valid low in LOAD / out_ready low in OUTPUT hold all registers; other states never stall.
//  byte_idx wraps 15->0 on every block boundary; never exceeds 15.
//  Latency (no stalls): start sampled at edge 0; LOAD cycles 1-16; rounds cycles 17-336 (32/round);
//    OUTPUT cycles 337-352; done high cycle 353; busy high cycles 1-352.
//  At most one of ke_en / sb_en / out_valid / load_en is high in any cycle.
//  start high on the done cycle begins a new block (LOAD next cycle).
// TESTING
//  1 Reset only -> all outputs 0, byte_idx=0, round=0, rcon=01, busy=0.
//  2 start pulse, in_valid=1, out_ready=1 -> done pulse exactly 353 cycles after start edge; busy 352 cycles.
//  3 Same run: log rcon at each KEYEXP entry -> 01,02,04,08,10,20,40,80,1b,36; mc_en=0 only in round 10 DATA.
//  4 in_valid low for 5 cycles at byte_idx=7 in LOAD -> byte_idx holds 7, load_en=0, done delayed by 5.
//  5 out_ready toggling 1/0 in OUTPUT -> exactly 16 accepted bytes, idx 0..15 in order, done after byte 15.
//  6 rst asserted in DATA round 4 -> immediate IDLE, no done; start pulsed during busy ignored; start on done cycle -> LOAD.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Control FSM for a byte-serial AES-128 encryption datapath.
// It walks one block through LOAD (key/plaintext capture plus round-0 whitening),
// then NR rounds of KEYEXP (16 key-expansion steps) and DATA (16 SubBytes/MixColumns/
// AddRoundKey steps), then OUTPUT (16 ciphertext bytes). It also supplies the round
// number, the Rcon value and the per-stage enables to the external byte datapath.
module aes_round_sequencer #(
  parameter int NR     = 10,
  parameter int NBYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       load_en,
  output logic       ke_en,
  output logic       sb_en,
  output logic       mc_en,
  output logic       ark_en,
  output logic       out_valid,
  output logic [3:0] byte_idx,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KEYEXP,
    DATA,
    OUTPUT
  } state_t;

  localparam logic [3:0] LAST_IDX   = 4'(NBYTES - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [7:0] RCON_FIRST = 8'h01;

  state_t state;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1; produces the next round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Sequencer state, byte/round counters, Rcon and the one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_idx <= 4'd0;
      round    <= 4'd0;
      rcon     <= RCON_FIRST;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            byte_idx <= 4'd0;
            round    <= 4'd0;
          end
        end
        LOAD: begin
          // The source can stall; advance only on an accepted byte.
          if (in_valid) begin
            if (byte_idx == LAST_IDX) begin
              state    <= KEYEXP;
              byte_idx <= 4'd0;
              round    <= 4'd1;
              rcon     <= RCON_FIRST;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        KEYEXP: begin
          if (byte_idx == LAST_IDX) begin
            state    <= DATA;
            byte_idx <= 4'd0;
          end else begin
            byte_idx <= byte_idx + 4'd1;
          end
        end
        DATA: begin
          if (byte_idx == LAST_IDX) begin
            byte_idx <= 4'd0;
            if (round < LAST_ROUND) begin
              state <= KEYEXP;
              round <= round + 4'd1;
              rcon  <= xtime(rcon);
            end else begin
              // Last round: round and rcon stay put through OUTPUT.
              state <= OUTPUT;
            end
          end else begin
            byte_idx <= byte_idx + 4'd1;
          end
        end
        OUTPUT: begin
          // The sink can stall; advance only on an accepted byte.
          if (out_ready) begin
            if (byte_idx == LAST_IDX) begin
              state    <= IDLE;
              byte_idx <= 4'd0;
              round    <= 4'd0;
              rcon     <= RCON_FIRST;
              done     <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          byte_idx <= 4'd0;
          round    <= 4'd0;
          rcon     <= RCON_FIRST;
        end
      endcase
    end
  end

  // Stage enables are decoded from the state register. load_en/ark_en in LOAD
  // follow in_valid so that round-0 whitening happens on the same accepted byte.
  assign busy      = (state != IDLE);
  assign load_en   = (state == LOAD) && in_valid;
  assign ke_en     = (state == KEYEXP);
  assign sb_en     = (state == DATA);
  assign mc_en     = (state == DATA) && (round != LAST_ROUND);
  assign ark_en    = (state == DATA) || ((state == LOAD) && in_valid);
  assign out_valid = (state == OUTPUT);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: a directed vector table for the
// no-stall run, hand-written sequences for stalls, reset and restart, and a long
// randomized run checked every cycle against a block-position reference model.
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy, load_en, ke_en, sb_en, mc_en, ark_en, out_valid, done;
  logic [3:0] byte_idx, round;
  logic [7:0] rcon;

  aes_round_sequencer #(.NR(10), .NBYTES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .load_en  (load_en),
    .ke_en    (ke_en),
    .sb_en    (sb_en),
    .mc_en    (mc_en),
    .ark_en   (ark_en),
    .out_valid(out_valid),
    .byte_idx (byte_idx),
    .round    (round),
    .rcon     (rcon),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [23:0] dut_vec;
  assign dut_vec = {busy, load_en, ke_en, sb_en, mc_en, ark_en, out_valid, done,
                    byte_idx, round, rcon};

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Reference model: the block is a single position counter.
  // -1 idle, 0..15 load bytes, 16..335 round steps (32 per round), 336..351 output bytes.
  int   pos = -1;
  logic done_m = 1'b0;

  // Monitors filled while ticking.
  int   tick_n = 0;
  logic [7:0] rcon_q [$];
  int   acc_q [$];
  int   last_acc_tick = -1;
  int   mc_low_n = 0;
  int   mc_low_bad = 0;
  int   done_seen = 0;

  function automatic logic [23:0] mk(input logic b, input logic l, input logic k,
                                     input logic s, input logic m, input logic a,
                                     input logic o, input logic d, input logic [3:0] i,
                                     input logic [3:0] r, input logic [7:0] c);
    return {b, l, k, s, m, a, o, d, i, r, c};
  endfunction

  function automatic logic [23:0] model_exp();
    int r, w;
    if (pos < 0)
      return mk(0, 0, 0, 0, 0, 0, 0, done_m, 4'd0, 4'd0, 8'h01);
    if (pos < 16)
      return mk(1, in_valid, 0, 0, 0, in_valid, 0, 0, 4'(pos), 4'd0, 8'h01);
    if (pos < 336) begin
      r = (pos - 16) / 32 + 1;
      w = (pos - 16) % 32;
      return mk(1, 0, (w < 16), (w >= 16), (w >= 16) && (r != 10), (w >= 16), 0, 0,
                4'(w % 16), 4'(r), rcon_tbl[r-1]);
    end
    return mk(1, 0, 0, 0, 0, 0, 1, 0, 4'(pos - 336), 4'd10, rcon_tbl[9]);
  endfunction

  task automatic model_reset();
    pos = -1;
    done_m = 1'b0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    done_m = 1'b0;
    if (pos < 0) begin
      if (start) pos = 0;
    end else if (pos < 16) begin
      if (in_valid) pos++;
    end else if (pos < 336) begin
      pos++;
    end else if (out_ready) begin
      if (pos == 351) begin
        pos = -1;
        done_m = 1'b1;
      end else begin
        pos++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // One clock: compare against the model at the falling edge, then advance.
  task automatic tick();
    @(negedge clk);
    check("model", 32'(dut_vec), 32'(model_exp()));
    if (ke_en && byte_idx == 4'd0) rcon_q.push_back(rcon);
    if (out_valid && out_ready) begin
      acc_q.push_back(int'(byte_idx));
      last_acc_tick = tick_n;
    end
    if (sb_en && !mc_en) begin
      mc_low_n++;
      if (round != 4'd10) mc_low_bad++;
    end
    if (done) done_seen++;
    @(posedge clk);
    model_step();
    tick_n++;
    #1;
  endtask

  typedef struct {
    int          cyc;
    logic        in_valid;
    logic        out_ready;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int k;
    int done_cyc;
    int busy_n;
    int cyc;
    int bad;

    tbl[0]  = '{1,   1'b1, 1'b1, mk(1, 1, 0, 0, 0, 1, 0, 0, 4'd0,  4'd0,  8'h01)};
    tbl[1]  = '{16,  1'b1, 1'b1, mk(1, 1, 0, 0, 0, 1, 0, 0, 4'd15, 4'd0,  8'h01)};
    tbl[2]  = '{17,  1'b1, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 0, 4'd0,  4'd1,  8'h01)};
    tbl[3]  = '{32,  1'b1, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 0, 4'd15, 4'd1,  8'h01)};
    tbl[4]  = '{33,  1'b1, 1'b1, mk(1, 0, 0, 1, 1, 1, 0, 0, 4'd0,  4'd1,  8'h01)};
    tbl[5]  = '{48,  1'b1, 1'b1, mk(1, 0, 0, 1, 1, 1, 0, 0, 4'd15, 4'd1,  8'h01)};
    tbl[6]  = '{49,  1'b1, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 0, 4'd0,  4'd2,  8'h02)};
    tbl[7]  = '{177, 1'b1, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 0, 4'd0,  4'd6,  8'h20)};
    tbl[8]  = '{305, 1'b1, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 0, 4'd0,  4'd10, 8'h36)};
    tbl[9]  = '{321, 1'b1, 1'b1, mk(1, 0, 0, 1, 0, 1, 0, 0, 4'd0,  4'd10, 8'h36)};
    tbl[10] = '{336, 1'b1, 1'b1, mk(1, 0, 0, 1, 0, 1, 0, 0, 4'd15, 4'd10, 8'h36)};
    tbl[11] = '{337, 1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 1, 0, 4'd0,  4'd10, 8'h36)};
    tbl[12] = '{352, 1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 1, 0, 4'd15, 4'd10, 8'h36)};
    tbl[13] = '{353, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 1, 4'd0,  4'd0,  8'h01)};
    tbl[14] = '{354, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 4'd0,  4'd0,  8'h01)};

    // Reset only.
    model_reset();
    repeat (3) tick();
    check("reset_vec", 32'(dut_vec), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 8'h01)));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rcon", 32'(rcon), 32'h01);
    rst = 1'b0;
    tick();

    // No-stall block driven by the vector table; rcon log and mc_en window.
    rcon_q.delete();
    mc_low_n = 0;
    mc_low_bad = 0;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    k = 0; done_cyc = -1; busy_n = 0;
    for (int c = 1; c <= 354; c++) begin
      if (k < 15 && tbl[k].cyc == c) begin
        in_valid = tbl[k].in_valid;
        out_ready = tbl[k].out_ready;
        #1;
        check($sformatf("vec_c%0d", c), 32'(dut_vec), 32'(tbl[k].exp));
        k++;
      end
      if (busy) busy_n++;
      if (done && done_cyc < 0) done_cyc = c;
      tick();
    end
    check("vec_entries", 32'(k), 32'd15);
    check("done_cycle", 32'(done_cyc), 32'd353);
    check("busy_cycles", 32'(busy_n), 32'd352);
    check("rcon_count", 32'(rcon_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < rcon_q.size(); i++)
      check($sformatf("rcon_r%0d", i + 1), 32'(rcon_q[i]), 32'(rcon_tbl[i]));
    check("mc_low_cycles", 32'(mc_low_n), 32'd16);
    check("mc_low_wrong_round", 32'(mc_low_bad), 32'd0);

    // in_valid low for 5 cycles at byte_idx 7 in LOAD.
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 1000) begin
      in_valid = !(cyc >= 8 && cyc <= 12);
      if (!in_valid) begin
        #1;
        check($sformatf("stall_idx_c%0d", cyc), 32'(byte_idx), 32'd7);
        check($sformatf("stall_load_en_c%0d", cyc), 32'(load_en), 32'd0);
      end
      tick();
      cyc++;
    end
    check("stall_done_cycle", 32'(cyc), 32'd358);

    // out_ready toggling through OUTPUT; start on the done cycle above.
    acc_q.delete();
    in_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 1000) begin
      out_ready = cyc[0];
      tick();
      cyc++;
    end
    check("accepted_bytes", 32'(acc_q.size()), 32'd16);
    bad = 0;
    foreach (acc_q[i]) if (acc_q[i] != i) bad++;
    check("accepted_order", 32'(bad), 32'd0);
    check("done_after_last_byte", 32'(tick_n), 32'(last_acc_tick + 1));
    check("done_pulse", 32'(done), 32'd1);

    // Reset in DATA of round 4, ignored start while busy, restart on done cycle.
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(sb_en && round == 4'd4) && cyc < 400) begin
      tick();
      cyc++;
    end
    check("reach_round4_data", 32'({sb_en, round}), 32'({1'b1, 4'd4}));
    repeat (5) tick();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_immediate", 32'(dut_vec), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 8'h01)));
    tick();
    tick();
    rst = 1'b0;
    done_seen = 0;
    repeat (5) tick();
    check("no_done_after_rst", 32'(done_seen), 32'd0);

    start = 1'b1;
    tick();
    cyc = 1;
    while (!done && cyc < 1000) begin
      start = (cyc == 40 || cyc == 200 || cyc == 340);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("busy_start_ignored", 32'(cyc), 32'd353);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_on_done", 32'({busy, load_en, ke_en, byte_idx, round}),
          32'({1'b1, 1'b1, 1'b0, 4'd0, 4'd0}));
    cyc = 0;
    while (!done && cyc < 1000) begin
      tick();
      cyc++;
    end
    check("restart_block_done", 32'(done), 32'd1);

    // Randomized traffic with occasional resets, checked every cycle by the model.
    for (int i = 0; i < 6000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
